// File: rtl/gpu_cmd_pkg.sv
// Shared command-word encoding for the GPU command control path (buffer, interface, dispatch).
package gpu_cmd_pkg;

    localparam logic [1:0] CMD_RESET = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_RSVD  = 2'b11;

    localparam logic [2:0] TGT_ALL   = 3'b000;
    localparam logic [2:0] TGT_HDR   = 3'b001;
    localparam logic [2:0] TGT_RAM   = 3'b010;
    localparam logic [2:0] TGT_PAL   = 3'b011;
    localparam logic [2:0] TGT_FLASH = 3'b100;

    localparam int unsigned TYPE_MSB      = 15;
    localparam int unsigned TYPE_LSB      = 14;
    localparam int unsigned TGT_MSB       = 13;
    localparam int unsigned TGT_LSB       = 11;
    localparam int unsigned LAYER_ALL_BIT = 5;
    localparam int unsigned LAYER_MSB     = 4;
    localparam int unsigned LAYER_LSB     = 0;
    localparam int unsigned SEL_MSB       = 10;
    localparam int unsigned SEL_LSB       = 6;
    localparam int unsigned RAM_ID_MSB    = 10;
    localparam int unsigned RAM_ID_LSB    = 3;

    typedef enum logic [1:0] {
        StIdle,
        StBcast,
        StRdWait
    } dispState_e;

    // Reserved type, reserved target, or read/write aimed at a clear-only target.
    function automatic logic cmdIsInvalid(input logic [15:0] cmd);
        logic [1:0] cmdType;
        logic [2:0] cmdTgt;
        cmdType = cmd[TYPE_MSB:TYPE_LSB];
        cmdTgt  = cmd[TGT_MSB:TGT_LSB];
        return (cmdType == CMD_RSVD) || (cmdTgt > TGT_FLASH) ||
               ((cmdType != CMD_RESET) && ((cmdTgt == TGT_ALL) || (cmdTgt == TGT_FLASH)));
    endfunction

endpackage

// File: rtl/ram_block_addr_tracker.sv
// Tracks repeated RAM commands: identical consecutive RAM accesses walk through the
// block offset, anything else restarts at offset 0.
module ram_block_addr_tracker #(
    parameter int unsigned LAYER_BLOCK_W = 10
) (
    input  logic                     pipelineClk,
    input  logic                     rst,
    input  logic                     cmdAccept,
    input  logic                     isRamAccess,
    input  logic [15:0]              command,
    output logic [LAYER_BLOCK_W-1:0] offsetNext
);

    logic [15:0]              lastCmdQ;
    logic                     lastValidQ;
    logic [LAYER_BLOCK_W-1:0] offsetQ;

    // Natural overflow of the offset gives the wrap without touching the layer ID.
    always_comb begin
        offsetNext = '0;
        if (lastValidQ && (command == lastCmdQ)) begin
            offsetNext = offsetQ + 1'b1;
        end
    end

    always_ff @(posedge pipelineClk or negedge rst) begin
        if (!rst) begin
            lastCmdQ   <= '0;
            lastValidQ <= 1'b0;
            offsetQ    <= '0;
        end else if (cmdAccept) begin
            if (isRamAccess) begin
                lastCmdQ   <= command;
                lastValidQ <= 1'b1;
                offsetQ    <= offsetNext;
            end else begin
                lastValidQ <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/gpu_command_dispatch.sv
// Dispatches decoded commands to the GPU memories: single/broadcast writes, RAM block
// transfers, reads with timeout and clear strobes.
module gpu_command_dispatch
    import gpu_cmd_pkg::*;
#(
    parameter int unsigned LAYER_BLOCK_W = 10,
    parameter int unsigned NUM_LAYERS    = 32,
    parameter int unsigned RD_TIMEOUT    = 15
) (
    input  logic                     pipelineClk,
    input  logic                     rst,
    input  logic                     cmdValid,
    input  logic [15:0]              gpuCommand,
    input  logic [15:0]              gpuData,
    output logic                     gpuBusy,
    output logic                     hdrWe,
    output logic [7:0]               hdrAddr,
    output logic                     palWe,
    output logic [9:0]               palAddr,
    output logic                     ramWe,
    output logic [LAYER_BLOCK_W+7:0] ramAddr,
    output logic [15:0]              memWdata,
    output logic                     rdReq,
    output logic [2:0]               rdTarget,
    output logic [LAYER_BLOCK_W+7:0] rdAddr,
    input  logic                     rdAck,
    input  logic [15:0]              rdData,
    output logic [15:0]              dataFromGpu,
    output logic [3:0]               memClear,
    output logic                     cmdErr
);

    localparam int unsigned RAM_ADDR_W = LAYER_BLOCK_W + 8;
    localparam int unsigned TIMER_W    = $clog2(RD_TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(RD_TIMEOUT - 1);
    localparam logic [4:0] LAYER_LAST = 5'(NUM_LAYERS - 1);

    dispState_e stateQ, stateD;
    logic [4:0]         layerCntQ, layerCntD;
    logic [TIMER_W-1:0] timerQ, timerD;
    logic               bcastPalQ, bcastPalD;
    logic [4:0]         bcastSelQ, bcastSelD;

    logic                  gpuBusyD, hdrWeD, palWeD, ramWeD, rdReqD, cmdErrD;
    logic [7:0]            hdrAddrD;
    logic [9:0]            palAddrD;
    logic [RAM_ADDR_W-1:0] ramAddrD, rdAddrD;
    logic [15:0]           memWdataD, dataFromGpuD;
    logic [2:0]            rdTargetD;
    logic [3:0]            memClearD;

    logic [1:0]  cmdType;
    logic [2:0]  cmdTgt;
    logic [4:0]  cmdLayer;
    logic [4:0]  cmdSel;
    logic        cmdBcast;
    logic        cmdBad;
    logic        accept;
    logic        isRamAccess;
    logic [LAYER_BLOCK_W-1:0] offsetNext;
    logic [RAM_ADDR_W-1:0]    ramCmdAddr;

    assign cmdType     = gpuCommand[TYPE_MSB:TYPE_LSB];
    assign cmdTgt      = gpuCommand[TGT_MSB:TGT_LSB];
    assign cmdLayer    = gpuCommand[LAYER_MSB:LAYER_LSB];
    assign cmdSel      = gpuCommand[SEL_MSB:SEL_LSB];
    assign cmdBcast    = gpuCommand[LAYER_ALL_BIT];
    assign cmdBad      = cmdIsInvalid(gpuCommand);
    assign accept      = cmdValid && !gpuBusy && (stateQ == StIdle);
    assign isRamAccess = !cmdBad && (cmdTgt == TGT_RAM) &&
                         ((cmdType == CMD_READ) || (cmdType == CMD_WRITE));
    assign ramCmdAddr  = {gpuCommand[RAM_ID_MSB:RAM_ID_LSB], offsetNext};

    ram_block_addr_tracker #(
        .LAYER_BLOCK_W(LAYER_BLOCK_W)
    ) uTracker (
        .pipelineClk(pipelineClk),
        .rst        (rst),
        .cmdAccept  (accept),
        .isRamAccess(isRamAccess),
        .command    (gpuCommand),
        .offsetNext (offsetNext)
    );

    always_comb begin
        stateD       = stateQ;
        layerCntD    = layerCntQ;
        timerD       = timerQ;
        bcastPalD    = bcastPalQ;
        bcastSelD    = bcastSelQ;
        hdrWeD       = 1'b0;
        palWeD       = 1'b0;
        ramWeD       = 1'b0;
        memClearD    = 4'b0000;
        cmdErrD      = 1'b0;
        hdrAddrD     = hdrAddr;
        palAddrD     = palAddr;
        ramAddrD     = ramAddr;
        memWdataD    = memWdata;
        rdReqD       = rdReq;
        rdTargetD    = rdTarget;
        rdAddrD      = rdAddr;
        dataFromGpuD = dataFromGpu;

        unique case (stateQ)
            StIdle: begin
                if (accept && cmdBad) begin
                    cmdErrD = 1'b1;
                end else if (accept) begin
                    unique case (cmdType)
                        CMD_RESET: begin
                            memClearD = (cmdTgt == TGT_ALL) ? 4'b1111
                                                            : 4'b0001 << (cmdTgt - 3'd1);
                        end
                        CMD_WRITE: begin
                            memWdataD = gpuData;
                            if (cmdTgt == TGT_RAM) begin
                                ramWeD   = 1'b1;
                                ramAddrD = ramCmdAddr;
                            end else begin
                                // Broadcast emits layer 0 now, the rest from StBcast.
                                if (cmdTgt == TGT_HDR) begin
                                    hdrWeD   = 1'b1;
                                    hdrAddrD = {cmdBcast ? 5'd0 : cmdLayer, cmdSel[2:0]};
                                end else begin
                                    palWeD   = 1'b1;
                                    palAddrD = {cmdBcast ? 5'd0 : cmdLayer, cmdSel};
                                end
                                if (cmdBcast) begin
                                    stateD    = StBcast;
                                    layerCntD = 5'd1;
                                    bcastPalD = (cmdTgt == TGT_PAL);
                                    bcastSelD = cmdSel;
                                end
                            end
                        end
                        CMD_READ: begin
                            stateD    = StRdWait;
                            timerD    = '0;
                            rdReqD    = 1'b1;
                            rdTargetD = cmdTgt;
                            if (cmdTgt == TGT_HDR) begin
                                rdAddrD = {{(RAM_ADDR_W-8){1'b0}}, cmdLayer, cmdSel[2:0]};
                            end else if (cmdTgt == TGT_PAL) begin
                                rdAddrD = {{(RAM_ADDR_W-10){1'b0}}, cmdLayer, cmdSel};
                            end else begin
                                rdAddrD = ramCmdAddr;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StBcast: begin
                if (bcastPalQ) begin
                    palWeD   = 1'b1;
                    palAddrD = {layerCntQ, bcastSelQ};
                end else begin
                    hdrWeD   = 1'b1;
                    hdrAddrD = {layerCntQ, bcastSelQ[2:0]};
                end
                if (layerCntQ == LAYER_LAST) begin
                    stateD = StIdle;
                end else begin
                    layerCntD = layerCntQ + 5'd1;
                end
            end
            StRdWait: begin
                if (rdAck) begin
                    dataFromGpuD = rdData;
                    rdReqD       = 1'b0;
                    stateD       = StIdle;
                end else if (timerQ == TIMER_LAST) begin
                    dataFromGpuD = 16'hDEAD;
                    cmdErrD      = 1'b1;
                    rdReqD       = 1'b0;
                    stateD       = StIdle;
                end else begin
                    timerD = timerQ + 1'b1;
                end
            end
            default: stateD = StIdle;
        endcase

        gpuBusyD = (stateQ != StIdle) || (stateD != StIdle);
    end

    always_ff @(posedge pipelineClk or negedge rst) begin
        if (!rst) begin
            stateQ      <= StIdle;
            layerCntQ   <= '0;
            timerQ      <= '0;
            bcastPalQ   <= 1'b0;
            bcastSelQ   <= '0;
            gpuBusy     <= 1'b0;
            hdrWe       <= 1'b0;
            palWe       <= 1'b0;
            ramWe       <= 1'b0;
            hdrAddr     <= '0;
            palAddr     <= '0;
            ramAddr     <= '0;
            memWdata    <= '0;
            rdReq       <= 1'b0;
            rdTarget    <= '0;
            rdAddr      <= '0;
            dataFromGpu <= '0;
            memClear    <= '0;
            cmdErr      <= 1'b0;
        end else begin
            stateQ      <= stateD;
            layerCntQ   <= layerCntD;
            timerQ      <= timerD;
            bcastPalQ   <= bcastPalD;
            bcastSelQ   <= bcastSelD;
            gpuBusy     <= gpuBusyD;
            hdrWe       <= hdrWeD;
            palWe       <= palWeD;
            ramWe       <= ramWeD;
            hdrAddr     <= hdrAddrD;
            palAddr     <= palAddrD;
            ramAddr     <= ramAddrD;
            memWdata    <= memWdataD;
            rdReq       <= rdReqD;
            rdTarget    <= rdTargetD;
            rdAddr      <= rdAddrD;
            dataFromGpu <= dataFromGpuD;
            memClear    <= memClearD;
            cmdErr      <= cmdErrD;
        end
    end

endmodule

// File: tb/tb_gpu_command_dispatch.sv
// Randomised bench for gpu_command_dispatch against a transaction-level reference model.
module tb_gpu_command_dispatch;

    localparam int LBW = 10;
    localparam int RAW = LBW + 8;

    logic            pipelineClk;
    logic            rst;
    logic            cmdValid;
    logic [15:0]     gpuCommand;
    logic [15:0]     gpuData;
    logic            gpuBusy;
    logic            hdrWe;
    logic [7:0]      hdrAddr;
    logic            palWe;
    logic [9:0]      palAddr;
    logic            ramWe;
    logic [RAW-1:0]  ramAddr;
    logic [15:0]     memWdata;
    logic            rdReq;
    logic [2:0]      rdTarget;
    logic [RAW-1:0]  rdAddr;
    logic            rdAck;
    logic [15:0]     rdData;
    logic [15:0]     dataFromGpu;
    logic [3:0]      memClear;
    logic            cmdErr;

    gpu_command_dispatch #(
        .LAYER_BLOCK_W(LBW),
        .NUM_LAYERS   (32),
        .RD_TIMEOUT   (15)
    ) dut (
        .pipelineClk(pipelineClk),
        .rst        (rst),
        .cmdValid   (cmdValid),
        .gpuCommand (gpuCommand),
        .gpuData    (gpuData),
        .gpuBusy    (gpuBusy),
        .hdrWe      (hdrWe),
        .hdrAddr    (hdrAddr),
        .palWe      (palWe),
        .palAddr    (palAddr),
        .ramWe      (ramWe),
        .ramAddr    (ramAddr),
        .memWdata   (memWdata),
        .rdReq      (rdReq),
        .rdTarget   (rdTarget),
        .rdAddr     (rdAddr),
        .rdAck      (rdAck),
        .rdData     (rdData),
        .dataFromGpu(dataFromGpu),
        .memClear   (memClear),
        .cmdErr     (cmdErr)
    );

    initial pipelineClk = 1'b0;
    always #5 pipelineClk = ~pipelineClk;

    int vecCount = 0;
    int errCount = 0;

    // Reference model state
    logic [15:0] mLastCmd = '0;
    bit          mLastValid = 0;
    int          mOffset = 0;
    logic [15:0] mData = '0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        mLastValid = 0;
        mOffset    = 0;
        mData      = '0;
    endtask

    // ackDelay: cycle of rdReq on which rdAck is returned; >15 means never.
    task automatic runCmd(input logic [15:0] cmd, input logic [15:0] data,
                          input int ackDelay, input logic [15:0] ackData);
        int typ, tgt, p, layer, sel, addr, off;
        int expKind, expBusy, expReqCycles, expRdAddr;
        bit expErr, expRead, bad, done;
        logic [3:0] expClear;
        int expAddr[$];
        int obsAddr[$];
        int obsKindMask, multi, wdataBad, clearCycles, errPulses, busyCycles, reqCycles;
        logic [3:0] obsClear;
        logic [2:0] obsRdTgt;
        logic [31:0] obsRdAddr;

        typ = int'(cmd[15:14]);
        tgt = int'(cmd[13:11]);
        p   = int'(cmd[10:0]);
        expKind = 0; expBusy = 0; expReqCycles = 0; expRdAddr = 0;
        expErr = 0; expRead = 0; expClear = 4'b0000; addr = 0;

        bad = (typ == 3) || (tgt > 4) || ((typ != 0) && ((tgt == 0) || (tgt == 4)));
        if (bad) begin
            expErr = 1;
            mLastValid = 0;
        end else if (typ == 0) begin
            expClear = (tgt == 0) ? 4'hF : 4'(1 << (tgt - 1));
            mLastValid = 0;
        end else begin
            layer = p % 32;
            if (tgt == 2) begin
                off = (mLastValid && cmd == mLastCmd) ? (mOffset + 1) % 1024 : 0;
                mOffset = off;
                mLastCmd = cmd;
                mLastValid = 1;
                addr = (p / 8) * 1024 + off;
            end else begin
                mLastValid = 0;
                sel  = (tgt == 1) ? (p / 64) % 8 : (p / 64) % 32;
                addr = (tgt == 1) ? layer * 8 + sel : layer * 32 + sel;
            end
            if (typ == 2) begin
                expKind = (tgt == 1) ? 1 : (tgt == 3) ? 2 : 3;
                if (tgt != 2 && ((p / 32) % 2 == 1)) begin
                    expBusy = 32;
                    for (int l = 0; l < 32; l++)
                        expAddr.push_back((tgt == 1) ? l * 8 + sel : l * 32 + sel);
                end else begin
                    expAddr.push_back(addr);
                end
            end else begin
                expRead = 1;
                expRdAddr = addr;
                if (ackDelay <= 15) begin
                    expReqCycles = ackDelay;
                    mData = ackData;
                end else begin
                    expReqCycles = 15;
                    mData = 16'hDEAD;
                    expErr = 1;
                end
            end
        end

        obsKindMask = 0; multi = 0; wdataBad = 0; clearCycles = 0; errPulses = 0;
        busyCycles = 0; reqCycles = 0; obsClear = 4'b0000; obsRdTgt = '0; obsRdAddr = '0;
        done = 0;

        @(negedge pipelineClk);
        checkVal("busy_before_accept", 32'(gpuBusy), 32'd0);
        cmdValid   = 1'b1;
        gpuCommand = cmd;
        gpuData    = data;
        for (int cyc = 1; cyc <= 80 && !done; cyc++) begin
            @(negedge pipelineClk);
            cmdValid   = 1'b0;
            gpuCommand = 16'($urandom);
            gpuData    = 16'($urandom);
            if ((32'(hdrWe) + 32'(palWe) + 32'(ramWe)) > 1) multi++;
            if (hdrWe) begin obsKindMask |= 2; obsAddr.push_back(int'(hdrAddr)); end
            if (palWe) begin obsKindMask |= 4; obsAddr.push_back(int'(palAddr)); end
            if (ramWe) begin obsKindMask |= 8; obsAddr.push_back(int'(ramAddr)); end
            if ((hdrWe || palWe || ramWe) && memWdata !== data) wdataBad++;
            if (memClear != 4'b0000) begin obsClear |= memClear; clearCycles++; end
            if (cmdErr) errPulses++;
            if (gpuBusy) busyCycles++;
            if (rdReq) begin
                reqCycles++;
                if (reqCycles == 1) begin obsRdTgt = rdTarget; obsRdAddr = 32'(rdAddr); end
            end
            if (expRead) begin
                rdAck  = rdReq && (reqCycles == ackDelay);
                rdData = rdAck ? ackData : 16'($urandom);
            end else begin
                // Stray acks outside a read must be ignored.
                rdAck  = ($urandom_range(0, 3) == 0);
                rdData = 16'($urandom);
            end
            if (!gpuBusy && cyc >= 2) done = 1;
        end
        rdAck = 1'b0;

        checkVal("cmd_completes", 32'(done), 32'd1);
        checkVal("strobe_count", 32'(obsAddr.size()), 32'(expAddr.size()));
        for (int i = 0; i < expAddr.size() && i < obsAddr.size(); i++)
            checkVal("strobe_addr", 32'(obsAddr[i]), 32'(expAddr[i]));
        checkVal("strobe_kind", 32'(obsKindMask), (expKind == 0) ? 32'd0 : 32'(1 << expKind));
        checkVal("strobe_overlap", 32'(multi), 32'd0);
        checkVal("strobe_wdata", 32'(wdataBad), 32'd0);
        checkVal("mem_clear", 32'(obsClear), 32'(expClear));
        checkVal("mem_clear_len", 32'(clearCycles), (expClear != 0) ? 32'd1 : 32'd0);
        checkVal("cmd_err", 32'(errPulses), 32'(expErr));
        if (expRead) begin
            checkVal("rd_req_cycles", 32'(reqCycles), 32'(expReqCycles));
            checkVal("rd_target", 32'(obsRdTgt), 32'(tgt));
            checkVal("rd_addr", obsRdAddr, 32'(expRdAddr));
        end else begin
            checkVal("busy_cycles", 32'(busyCycles), 32'(expBusy));
        end
        checkVal("data_from_gpu", 32'(dataFromGpu), 32'(mData));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] cmd, prevCmd;
        int strobes, budget;

        rst = 1'b0; cmdValid = 1'b0; gpuCommand = '0; gpuData = '0; rdAck = 1'b0; rdData = '0;
        modelReset();
        repeat (3) @(negedge pipelineClk);
        checkVal("rst_busy", 32'(gpuBusy), 32'd0);
        checkVal("rst_strobes", {29'd0, hdrWe, palWe, ramWe}, 32'd0);
        checkVal("rst_ram_addr", 32'(ramAddr), 32'd0);
        checkVal("rst_rd_req", 32'(rdReq), 32'd0);
        checkVal("rst_data_from_gpu", 32'(dataFromGpu), 32'd0);
        checkVal("rst_clear_err", {27'd0, memClear, cmdErr}, 32'd0);
        checkVal("rst_rd_target", 32'(rdTarget), 32'd0);
        rst = 1'b1;

        runCmd(16'h8848, 16'h1234, 0, 16'h0);
        runCmd(16'h98E0, 16'h7FFF, 0, 16'h0);
        runCmd(16'h9018, 16'h0001, 0, 16'h0);
        runCmd(16'h9018, 16'h0002, 0, 16'h0);
        runCmd(16'h9018, 16'h0003, 0, 16'h0);
        runCmd(16'h9020, 16'h0004, 0, 16'h0);
        runCmd(16'h5848, 16'h0000, 4, 16'hBEEF);
        runCmd(16'h5848, 16'h0000, 99, 16'h0);
        runCmd(16'h0000, 16'h0000, 0, 16'h0);
        runCmd(16'hE800, 16'h5555, 0, 16'h0);

        // Walk one RAM block past its last offset to reach the wrap.
        for (int i = 0; i < 1026; i++) runCmd(16'h9018, 16'($urandom), 0, 16'h0);
        runCmd(16'h5018, 16'h0000, 2, 16'h1357);

        prevCmd = 16'h9018;
        for (int i = 0; i < 400; i++) begin
            cmd = ($urandom_range(0, 9) < 3) ? prevCmd : 16'($urandom);
            runCmd(cmd, 16'($urandom), $urandom_range(1, 18), 16'($urandom));
            prevCmd = cmd;
        end

        // Reset in the middle of a broadcast.
        @(negedge pipelineClk);
        cmdValid = 1'b1; gpuCommand = 16'h98E0; gpuData = 16'h7FFF;
        strobes = 0;
        budget = 0;
        while (strobes < 10 && budget < 40) begin
            @(negedge pipelineClk);
            cmdValid = 1'b0;
            if (palWe) strobes++;
            budget++;
        end
        checkVal("bcast_reached_10", 32'(strobes), 32'd10);
        rst = 1'b0;
        #1;
        checkVal("midrst_strobes", {29'd0, hdrWe, palWe, ramWe}, 32'd0);
        checkVal("midrst_busy", 32'(gpuBusy), 32'd0);
        modelReset();
        repeat (2) @(negedge pipelineClk);
        rst = 1'b1;
        strobes = 0;
        budget = 0;
        repeat (6) begin
            @(negedge pipelineClk);
            if (hdrWe || palWe || ramWe) strobes++;
            if (gpuBusy) budget++;
        end
        checkVal("post_rst_strobes", 32'(strobes), 32'd0);
        checkVal("post_rst_busy", 32'(budget), 32'd0);
        runCmd(16'h9018, 16'hAAAA, 0, 16'h0);
        runCmd(16'h8848, 16'h1234, 0, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
